// File: rtl/pc_unit.sv
`default_nettype none
// ============================================================================
// Module   : pc_unit
// Brief    : Program counter with branch/jump/jal/ret modes, return-address
//            stack, exception entry/return and misaligned-target trapping.
// Revision : 1.0 - initial release
// ============================================================================
module pc_unit #(
    parameter int          XLEN         = 32,
    parameter logic [31:0] RESET_VECTOR = 32'h0000_3000,
    parameter logic [31:0] EXC_VECTOR   = 32'h0000_4180,
    parameter int          RAS_DEPTH    = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         pc_wr,
    input  logic [2:0]                   npc_sel,
    input  logic [1:0]                   cond_mode,
    input  logic                         zero,
    input  logic [25:0]                  imm,
    input  logic [XLEN-1:0]              rs_val,
    input  logic                         exc_req,
    input  logic                         eret,
    output logic [XLEN-1:0]              pc,
    output logic [XLEN-1:0]              pc_next,
    output logic [XLEN-1:0]              epc,
    output logic                         in_exc,
    output logic [$clog2(RAS_DEPTH):0]   ras_count,
    output logic                         addr_err
);

    localparam int              c_ptr_w   = $clog2(RAS_DEPTH);
    localparam logic [XLEN-1:0] c_rst_vec = XLEN'(RESET_VECTOR);
    localparam logic [XLEN-1:0] c_exc_vec = XLEN'(EXC_VECTOR);

    localparam logic [2:0] c_sel_cond = 3'b001;
    localparam logic [2:0] c_sel_j    = 3'b010;
    localparam logic [2:0] c_sel_jr   = 3'b011;
    localparam logic [2:0] c_sel_jal  = 3'b100;
    localparam logic [2:0] c_sel_ret  = 3'b101;

    logic [XLEN-1:0]    r_pc;
    logic [XLEN-1:0]    r_epc;
    logic               r_in_exc;
    logic               r_addr_err;
    logic [c_ptr_w-1:0] r_ptr;
    logic [c_ptr_w:0]   r_count;
    logic [XLEN-1:0]    r_ras [RAS_DEPTH];

    logic [XLEN-1:0]    w_p4;
    logic [XLEN-1:0]    w_btgt;
    logic [XLEN-1:0]    w_jtgt;
    logic [XLEN-1:0]    w_ras_top;
    logic [XLEN-1:0]    w_ind_tgt;
    logic [XLEN-1:0]    w_pc_next;
    logic               w_taken;
    logic               w_push;
    logic               w_pop;
    logic               w_trap;
    logic               w_exc;
    logic               w_eret;

    assign w_p4      = r_pc + XLEN'(4);
    assign w_btgt    = w_p4 + {{(XLEN-18){imm[15]}}, imm[15:0], 2'b00};
    assign w_jtgt    = {w_p4[XLEN-1:28], imm, 2'b00};
    // Top of stack sits just below the write pointer; power-of-two depth wraps for free.
    assign w_ras_top = r_ras[r_ptr - c_ptr_w'(1)];
    assign w_taken   = ((cond_mode == 2'b00) &  zero) |
                       ((cond_mode == 2'b01) & ~zero) |
                        (cond_mode == 2'b10);

    always_comb begin
        w_pc_next = w_p4;
        w_ind_tgt = rs_val;
        w_push    = 1'b0;
        w_pop     = 1'b0;
        w_trap    = 1'b0;
        w_exc     = 1'b0;
        w_eret    = 1'b0;
        if (exc_req) begin
            w_pc_next = c_exc_vec;
            w_exc     = 1'b1;
        end else if (eret && r_in_exc) begin
            w_pc_next = r_epc;
            w_eret    = 1'b1;
        end else if (!eret) begin
            case (npc_sel)
                c_sel_cond: if (w_taken) w_pc_next = w_btgt;
                c_sel_j:    w_pc_next = w_jtgt;
                c_sel_jr: begin
                    w_pc_next = w_ind_tgt;
                    w_trap    = |w_ind_tgt[1:0];
                end
                c_sel_jal: begin
                    w_pc_next = w_jtgt;
                    w_push    = 1'b1;
                end
                c_sel_ret: begin
                    if (r_count != '0) begin
                        w_pop     = 1'b1;
                        w_ind_tgt = w_ras_top;
                    end
                    w_pc_next = w_ind_tgt;
                    w_trap    = |w_ind_tgt[1:0];
                end
                default: ;
            endcase
            // A misaligned indirect target becomes an exception entry.
            if (w_trap) begin
                w_pc_next = c_exc_vec;
                w_exc     = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc       <= c_rst_vec;
            r_epc      <= c_rst_vec;
            r_in_exc   <= 1'b0;
            r_addr_err <= 1'b0;
            r_ptr      <= '0;
            r_count    <= '0;
        end else begin
            r_addr_err <= 1'b0;
            if (pc_wr) begin
                r_pc       <= w_pc_next;
                r_addr_err <= w_trap;
                if (w_exc && !r_in_exc) begin
                    r_epc    <= r_pc;
                    r_in_exc <= 1'b1;
                end
                if (w_eret) r_in_exc <= 1'b0;
                if (w_push) begin
                    r_ptr <= r_ptr + c_ptr_w'(1);
                    if (r_count != (c_ptr_w+1)'(RAS_DEPTH)) r_count <= r_count + 1'b1;
                end
                if (w_pop) begin
                    r_ptr   <= r_ptr - c_ptr_w'(1);
                    r_count <= r_count - 1'b1;
                end
            end
        end
    end

    // Stack contents need no reset: the count gates every read.
    always_ff @(posedge clk) begin
        if (!rst && pc_wr && w_push) r_ras[r_ptr] <= w_p4;
    end

    assign pc        = r_pc;
    assign pc_next   = w_pc_next;
    assign epc       = r_epc;
    assign in_exc    = r_in_exc;
    assign ras_count = r_count;
    assign addr_err  = r_addr_err;

endmodule
`default_nettype wire

// File: tb/tb_pc_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_unit
// Brief    : Directed scoreboard bench for pc_unit (default parameters).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_unit;

    logic        clk;
    logic        rst;
    logic        pc_wr;
    logic [2:0]  npc_sel;
    logic [1:0]  cond_mode;
    logic        zero;
    logic [25:0] imm;
    logic [31:0] rs_val;
    logic        exc_req;
    logic        eret;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic [31:0] epc;
    logic        in_exc;
    logic [2:0]  ras_count;
    logic        addr_err;

    int n_total;
    int n_pass;

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic [31:0] epc;
        logic        inx;
        logic [2:0]  cnt;
        logic        ae;
    } exp_t;

    exp_t q[$];

    pc_unit dut (
        .clk       (clk),
        .rst       (rst),
        .pc_wr     (pc_wr),
        .npc_sel   (npc_sel),
        .cond_mode (cond_mode),
        .zero      (zero),
        .imm       (imm),
        .rs_val    (rs_val),
        .exc_req   (exc_req),
        .eret      (eret),
        .pc        (pc),
        .pc_next   (pc_next),
        .epc       (epc),
        .in_exc    (in_exc),
        .ras_count (ras_count),
        .addr_err  (addr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string n, input string f, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act !== req)
            $display("FAIL %s.%s: got %h, expected %h", n, f, act, req);
        else
            n_pass++;
    endtask

    // Monitor: registered outputs settle after the edge that consumed the stimulus.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                check(e.name, "pc",        pc,                 e.pc);
                check(e.name, "epc",       epc,                e.epc);
                check(e.name, "in_exc",    {31'd0, in_exc},    {31'd0, e.inx});
                check(e.name, "ras_count", {29'd0, ras_count}, {29'd0, e.cnt});
                check(e.name, "addr_err",  {31'd0, addr_err},  {31'd0, e.ae});
            end
        end
    end

    task automatic defaults();
        rst = 1'b0; pc_wr = 1'b0; npc_sel = 3'd0; cond_mode = 2'd0; zero = 1'b0;
        imm = 26'd0; rs_val = 32'd0; exc_req = 1'b0; eret = 1'b0;
    endtask

    task automatic step(input logic [2:0] sel, input logic [25:0] im, input logic [31:0] rs);
        defaults();
        pc_wr = 1'b1; npc_sel = sel; imm = im; rs_val = rs;
    endtask

    task automatic go(input string n, input logic [31:0] p, input logic [31:0] e,
                      input logic x, input logic [2:0] c, input logic a);
        exp_t t;
        t.name = n; t.pc = p; t.epc = e; t.inx = x; t.cnt = c; t.ae = a;
        q.push_back(t);
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        n_total = 0;
        n_pass  = 0;
        defaults();

        rst = 1'b1; pc_wr = 1'b1; exc_req = 1'b1; npc_sel = 3'd4;
        go("reset", 32'h3000, 32'h3000, 0, 0, 0);

        step(3'd0, 0, 0); go("seq1", 32'h3004, 32'h3000, 0, 0, 0);
        step(3'd0, 0, 0); go("seq2", 32'h3008, 32'h3000, 0, 0, 0);
        step(3'd0, 0, 0); go("seq3", 32'h300C, 32'h3000, 0, 0, 0);
        defaults(); exc_req = 1'b1; eret = 1'b1; npc_sel = 3'd2;
        go("hold1", 32'h300C, 32'h3000, 0, 0, 0);
        defaults(); go("hold2", 32'h300C, 32'h3000, 0, 0, 0);
        step(3'd0, 0, 0); go("seq4", 32'h3010, 32'h3000, 0, 0, 0);

        step(3'd1, 26'h000FFFE, 0); cond_mode = 2'b00; zero = 1'b1;
        go("beq_t", 32'h300C, 32'h3000, 0, 0, 0);
        step(3'd2, 26'h0000C04, 0); go("j3010a", 32'h3010, 32'h3000, 0, 0, 0);
        step(3'd1, 26'h000FFFE, 0); cond_mode = 2'b00; zero = 1'b0;
        go("beq_nt", 32'h3014, 32'h3000, 0, 0, 0);
        step(3'd2, 26'h0000C04, 0); go("j3010b", 32'h3010, 32'h3000, 0, 0, 0);
        step(3'd1, 26'h000FFFE, 0); cond_mode = 2'b01; zero = 1'b1;
        go("bne_nt", 32'h3014, 32'h3000, 0, 0, 0);
        step(3'd2, 26'h0000C04, 0); go("j3010c", 32'h3010, 32'h3000, 0, 0, 0);
        step(3'd1, 26'h000FFFE, 0); cond_mode = 2'b01; zero = 1'b0;
        go("bne_t", 32'h300C, 32'h3000, 0, 0, 0);
        step(3'd2, 26'h0000C04, 0); go("j3010d", 32'h3010, 32'h3000, 0, 0, 0);
        step(3'd1, 26'h000FFFE, 0); cond_mode = 2'b11; zero = 1'b1;
        go("bnever", 32'h3014, 32'h3000, 0, 0, 0);
        step(3'd2, 26'h0000C04, 0); go("j3010e", 32'h3010, 32'h3000, 0, 0, 0);
        step(3'd1, 26'h0000004, 0); cond_mode = 2'b10; zero = 1'b0;
        go("balw_fwd", 32'h3024, 32'h3000, 0, 0, 0);

        step(3'd2, 26'h0000C00, 0); go("j3000", 32'h3000, 32'h3000, 0, 0, 0);
        step(3'd4, 26'h0000C40, 0); go("jal1", 32'h3100, 32'h3000, 0, 1, 0);
        step(3'd4, 26'h0000C80, 0); go("jal2", 32'h3200, 32'h3000, 0, 2, 0);
        step(3'd4, 26'h0000CC0, 0); go("jal3", 32'h3300, 32'h3000, 0, 3, 0);
        step(3'd4, 26'h0000D00, 0); go("jal4", 32'h3400, 32'h3000, 0, 4, 0);
        step(3'd4, 26'h0000D40, 0); go("jal5", 32'h3500, 32'h3000, 0, 4, 0);
        step(3'd5, 0, 32'h3700); go("ret1", 32'h3404, 32'h3000, 0, 3, 0);
        step(3'd5, 0, 32'h3700); go("ret2", 32'h3304, 32'h3000, 0, 2, 0);
        step(3'd5, 0, 32'h3700); go("ret3", 32'h3204, 32'h3000, 0, 1, 0);
        step(3'd5, 0, 32'h3700); go("ret4", 32'h3104, 32'h3000, 0, 0, 0);
        step(3'd5, 0, 32'h3600); go("ret_empty", 32'h3600, 32'h3000, 0, 0, 0);

        step(3'd2, 26'h0000C08, 0); go("j3020", 32'h3020, 32'h3000, 0, 0, 0);
        step(3'd0, 0, 0); exc_req = 1'b1;
        go("exc", 32'h4180, 32'h3020, 1, 0, 0);
        step(3'd0, 0, 0); exc_req = 1'b1; eret = 1'b1;
        go("exc_nest", 32'h4180, 32'h3020, 1, 0, 0);
        step(3'd2, 26'h0000C00, 0); eret = 1'b1;
        go("eret", 32'h3020, 32'h3020, 0, 0, 0);
        step(3'd2, 26'h0000C00, 0); eret = 1'b1;
        go("eret_noexc", 32'h3024, 32'h3020, 0, 0, 0);

        step(3'd3, 0, 32'h3102); go("jr_mis", 32'h4180, 32'h3024, 1, 0, 1);
        defaults(); go("aerr_clr", 32'h4180, 32'h3024, 1, 0, 0);
        step(3'd0, 0, 0); eret = 1'b1;
        go("eret2", 32'h3024, 32'h3024, 0, 0, 0);
        step(3'd3, 0, 32'h3100); go("jr_ok", 32'h3100, 32'h3024, 0, 0, 0);

        step(3'd4, 26'h0000C80, 0); go("jal6", 32'h3200, 32'h3024, 0, 1, 0);
        step(3'd5, 0, 32'h3700); go("ret5", 32'h3104, 32'h3024, 0, 0, 0);
        step(3'd5, 0, 32'h3602); go("ret_mis", 32'h4180, 32'h3104, 1, 0, 1);
        step(3'd3, 0, 32'h3001); go("jr_mis_nest", 32'h4180, 32'h3104, 1, 0, 1);

        step(3'd4, 26'h0000C40, 0); go("jal7", 32'h3100, 32'h3104, 1, 1, 0);
        step(3'd4, 26'h0000C40, 0); go("jal8", 32'h3100, 32'h3104, 1, 2, 0);
        step(3'd4, 26'h0000C40, 0); go("jal9", 32'h3100, 32'h3104, 1, 3, 0);
        step(3'd0, 0, 0); rst = 1'b1; exc_req = 1'b1;
        go("rst_mid", 32'h3000, 32'h3000, 0, 0, 0);
        step(3'd0, 0, 0); go("seq_after", 32'h3004, 32'h3000, 0, 0, 0);

        defaults();
        repeat (3) @(negedge clk);
        if (q.size() != 0) begin
            n_total++;
            $display("FAIL drain: got %0d pending, expected 0", q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
